// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice: datapath selects, opcodes/functs,
// FSM states and the decoded instruction-class record. Optional CP0 support: MIPS_CTRL_EXC_EN.
package mips_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_DCD   = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_EXC   = 3'd6
  } state_e;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HIGH = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;
  localparam logic [1:0] RD_RS  = 2'd3;

  localparam logic [2:0] M2R_ALUOUT = 3'd0;
  localparam logic [2:0] M2R_DR     = 3'd1;
  localparam logic [2:0] M2R_HI     = 3'd2;
  localparam logic [2:0] M2R_LO     = 3'd3;
  localparam logic [2:0] M2R_PRDIN  = 3'd4;
  localparam logic [2:0] M2R_CP0    = 3'd5;

  localparam logic [1:0] SA_GPR_A = 2'd0;
  localparam logic [1:0] SA_PC    = 2'd1;
  localparam logic [1:0] SA_SA    = 2'd2;

  localparam logic [1:0] SB_EXT     = 2'd0;
  localparam logic [1:0] SB_GPR_B   = 2'd1;
  localparam logic [1:0] SB_PCCYCLE = 2'd2;
  localparam logic [1:0] SB_EXT2    = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_ERET = 6'h18;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [4:0] RS_MFC0 = 5'h00;
  localparam logic [4:0] RS_MTC0 = 5'h04;

  // alu_op/ext_op are what the EXE state drives for this instruction.
  typedef struct packed {
    logic       rtype;
    logic       shift;
    logic       imm;
    logic       lw;
    logic       sw;
    logic       br;
    logic       bne;
    logic       jr;
    logic       j;
    logic       jal;
    logic       mfhi;
    logic       mflo;
`ifdef MIPS_CTRL_EXC_EN
    logic       mfc0;
    logic       mtc0;
    logic       eret;
`endif
    logic       illegal;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
  } insn_flags_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational op/funct -> instruction-class decode for the multi-cycle control FSM.
// With MIPS_CTRL_EXC_EN the CP0 opcodes (mfc0/mtc0/eret) are legal; otherwise they decode illegal.
module mips_ctrl_decode
  import mips_mc_ctrl_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
`ifdef MIPS_CTRL_EXC_EN
  input  logic [4:0]  rs_i,
`endif
  output insn_flags_t flags_o
);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    flags_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADDU:  begin flags_o.rtype = 1'b1; flags_o.alu_op = ALU_ADD; end
          F_SUBU:  begin flags_o.rtype = 1'b1; flags_o.alu_op = ALU_SUB; end
          F_OR:    begin flags_o.rtype = 1'b1; flags_o.alu_op = ALU_OR;  end
          F_SLT:   begin flags_o.rtype = 1'b1; flags_o.alu_op = ALU_SLT; end
          F_SLL:   begin flags_o.shift = 1'b1; flags_o.alu_op = ALU_SLL; end
          F_SRL:   begin flags_o.shift = 1'b1; flags_o.alu_op = ALU_SRL; end
          F_JR:    flags_o.jr      = 1'b1;
          F_MFHI:  flags_o.mfhi    = 1'b1;
          F_MFLO:  flags_o.mflo    = 1'b1;
          default: flags_o.illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin
        flags_o.imm    = 1'b1;
        flags_o.alu_op = ALU_ADD;
        flags_o.ext_op = EXT_SIGN;
      end
      OP_ORI: begin
        flags_o.imm    = 1'b1;
        flags_o.alu_op = ALU_OR;
        flags_o.ext_op = EXT_ZERO;
      end
      OP_LUI: begin
        flags_o.imm    = 1'b1;
        flags_o.alu_op = ALU_OR;
        flags_o.ext_op = EXT_HIGH;
      end
      OP_LW: begin
        flags_o.lw     = 1'b1;
        flags_o.alu_op = ALU_ADD;
        flags_o.ext_op = EXT_SIGN;
      end
      OP_SW: begin
        flags_o.sw     = 1'b1;
        flags_o.alu_op = ALU_ADD;
        flags_o.ext_op = EXT_SIGN;
      end
      OP_BEQ: begin
        flags_o.br     = 1'b1;
        flags_o.alu_op = ALU_SUB;
        flags_o.ext_op = EXT_SIGN;
      end
      OP_BNE: begin
        flags_o.br     = 1'b1;
        flags_o.bne    = 1'b1;
        flags_o.alu_op = ALU_SUB;
        flags_o.ext_op = EXT_SIGN;
      end
      OP_J:   flags_o.j   = 1'b1;
      OP_JAL: flags_o.jal = 1'b1;
`ifdef MIPS_CTRL_EXC_EN
      OP_COP0: begin
        if (funct_i == F_ERET)    flags_o.eret    = 1'b1;
        else if (rs_i == RS_MFC0) flags_o.mfc0    = 1'b1;
        else if (rs_i == RS_MTC0) flags_o.mtc0    = 1'b1;
        else                      flags_o.illegal = 1'b1;
      end
`endif
      default: flags_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences FETCH/DCD/EXE/MEM/WB and drives all datapath
// selects and strobes. Optional MIPS_CTRL_EXC_EN adds interrupt entry (S_EXC) and CP0 ops.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
`ifdef MIPS_CTRL_EXC_EN
  input  logic [4:0] rs,
  input  logic       int_req,
  input  logic       ie,
  output logic       EPCWr,
  output logic       ExlSet,
  output logic       CP0Wr,
`endif
  output logic       mem_req,
  output logic       mem_sel,
  output logic       PCWr,
  output logic       IRWr,
  output logic       GPRWr,
  output logic       DMWr,
  output logic [1:0] NPCOp,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [2:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       illegal,
  output logic       mem_err
);

  state_e      state_q, state_d;
  insn_flags_t flags;
  logic        tmo;
  logic        exe_to_fetch;

  mips_ctrl_decode u_decode (
    .op_i    (op),
    .funct_i (funct),
`ifdef MIPS_CTRL_EXC_EN
    .rs_i    (rs),
`endif
    .flags_o (flags)
  );

`ifdef MIPS_CTRL_EXC_EN
  assign exe_to_fetch = flags.br | flags.jr | flags.mtc0 | flags.eret;
`else
  assign exe_to_fetch = flags.br | flags.jr;
`endif

  // Memory wait watchdog; absent entirely when MEM_TIMEOUT is 0 (wait forever).
  generate
    if (MEM_TIMEOUT == 0) begin : g_no_tmo
      assign tmo = 1'b0;
    end else begin : g_tmo
      localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
      logic [CW-1:0] wait_q, wait_d;
      logic          waiting;

      assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_rdy;
      assign tmo     = waiting && (wait_q == CW'(MEM_TIMEOUT));

      always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || tmo) wait_d = '0;
        else if (waiting)                wait_d = wait_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
      end
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_sel  = 1'b0;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    GPRWr    = 1'b0;
    DMWr     = 1'b0;
    NPCOp    = NPC_PC4;
    ExtOp    = EXT_ZERO;
    ALUOp    = ALU_ADD;
    RegDst   = RD_RT;
    MemtoReg = M2R_ALUOUT;
    ALUSrcA  = SA_GPR_A;
    ALUSrcB  = SB_EXT;
    illegal  = 1'b0;
    mem_err  = 1'b0;
`ifdef MIPS_CTRL_EXC_EN
    EPCWr    = 1'b0;
    ExlSet   = 1'b0;
    CP0Wr    = 1'b0;
`endif

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = S_DCD;
        end else if (tmo) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_DCD: begin
        if (flags.illegal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (flags.j) begin
          PCWr    = 1'b1;
          NPCOp   = NPC_J;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        ALUOp = flags.alu_op;
        ExtOp = flags.ext_op;
        if (flags.rtype || flags.shift || flags.br) ALUSrcB = SB_GPR_B;
        if (flags.shift) ALUSrcA = SA_SA;
        if (flags.jal) begin
          ALUSrcA = SA_PC;
          ALUSrcB = SB_PCCYCLE;
        end
        // bne flips the sense of the zero flag.
        if (flags.br && (flags.bne ^ zero)) begin
          PCWr  = 1'b1;
          NPCOp = NPC_BR;
        end
        if (flags.jr) begin
          PCWr  = 1'b1;
          NPCOp = NPC_JR;
        end
`ifdef MIPS_CTRL_EXC_EN
        if (flags.mtc0) CP0Wr = 1'b1;
        // EPC is steered onto the register-jump path externally while eret is in IR.
        if (flags.eret) begin
          PCWr  = 1'b1;
          NPCOp = NPC_JR;
        end
`endif
        if (flags.lw || flags.sw) state_d = S_MEM;
        else if (exe_to_fetch)    state_d = S_FETCH;
        else                      state_d = S_WB;
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        DMWr    = flags.sw & ~tmo;
        if (mem_rdy) begin
          state_d = flags.sw ? S_FETCH : S_WB;
        end else if (tmo) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        GPRWr   = 1'b1;
        state_d = S_FETCH;
        if (flags.rtype || flags.shift || flags.mfhi || flags.mflo) RegDst = RD_RD;
        if (flags.lw)   MemtoReg = M2R_DR;
        if (flags.mfhi) MemtoReg = M2R_HI;
        if (flags.mflo) MemtoReg = M2R_LO;
`ifdef MIPS_CTRL_EXC_EN
        if (flags.mfc0) MemtoReg = M2R_CP0;
`endif
        if (flags.jal) begin
          RegDst = RD_R31;
          PCWr   = 1'b1;
          NPCOp  = NPC_J;
        end
      end

`ifdef MIPS_CTRL_EXC_EN
      S_EXC: begin
        EPCWr   = 1'b1;
        ExlSet  = 1'b1;
        PCWr    = 1'b1;
        NPCOp   = NPC_JR;
        state_d = S_FETCH;
      end
`endif

      default: state_d = S_INIT;
    endcase

`ifdef MIPS_CTRL_EXC_EN
    // Interrupts are taken on entry to FETCH, before any instruction request is issued.
    if ((state_d == S_FETCH) && ((state_q != S_FETCH) || tmo) && (state_q != S_EXC) &&
        int_req && ie)
      state_d = S_EXC;
`endif
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-instruction stage-schedule model, directed scenarios
// with literal expectations, then randomized instructions/memory latency with MEM_TIMEOUT=5.
module tb_mips_mc_ctrl;

  localparam int T = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_rdy;
  logic       mem_req, mem_sel, PCWr, IRWr, GPRWr, DMWr;
  logic [1:0] NPCOp, ExtOp, RegDst, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp, MemtoReg;
  logic       illegal, mem_err;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_sel(mem_sel), .PCWr(PCWr), .IRWr(IRWr), .GPRWr(GPRWr),
    .DMWr(DMWr), .NPCOp(NPCOp), .ExtOp(ExtOp), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .illegal(illegal),
    .mem_err(mem_err)
  );

  typedef struct packed {
    logic       mem_req, mem_sel, pcwr, irwr, gprwr, dmwr;
    logic [1:0] npc, ext;
    logic [2:0] alu;
    logic [1:0] regdst;
    logic [2:0] m2r;
    logic [1:0] srca, srcb;
    logic       illegal, mem_err;
  } outs_t;

  typedef enum {C_ADDU, C_SUBU, C_OR, C_SLT, C_SLL, C_SRL, C_JR, C_MFHI, C_MFLO,
                C_ADDIU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL} cls_e;

  outs_t dut_outs;
  assign dut_outs = {mem_req, mem_sel, PCWr, IRWr, GPRWr, DMWr, NPCOp, ExtOp, ALUOp,
                     RegDst, MemtoReg, ALUSrcA, ALUSrcB, illegal, mem_err};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit in_init;
  int idx, w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cls_e classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h21: return C_ADDU;
        6'h23: return C_SUBU;
        6'h25: return C_OR;
        6'h2A: return C_SLT;
        6'h00: return C_SLL;
        6'h02: return C_SRL;
        6'h08: return C_JR;
        6'h10: return C_MFHI;
        6'h12: return C_MFLO;
        default: return C_ILL;
      endcase
    end
    case (o)
      6'h09: return C_ADDIU;
      6'h0D: return C_ORI;
      6'h0F: return C_LUI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h05: return C_BNE;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // Stage letters an instruction passes through with zero-wait memory (length = CPI).
  function automatic string seq_of(input cls_e c);
    case (c)
      C_LW:               return "FDEMW";
      C_SW:               return "FDEM";
      C_BEQ, C_BNE, C_JR: return "FDE";
      C_J, C_ILL:         return "FD";
      default:            return "FDEW";
    endcase
  endfunction

  function automatic byte stage_now();
    string s;
    if (in_init) return "I";
    s = seq_of(classify(op, funct));
    return s[idx];
  endfunction

  function automatic bit fire_now();
    byte st;
    st = stage_now();
    return ((st == "F") || (st == "M")) && !mem_rdy && (T > 0) && (w == T);
  endfunction

  function automatic outs_t expect_out();
    outs_t e;
    cls_e  c;
    byte   st;
    bit    fire;
    e = '0;
    if (!rst_n || in_init) return e;
    c    = classify(op, funct);
    st   = stage_now();
    fire = fire_now();
    case (st)
      "F": begin
        e.mem_req = 1'b1;
        if (mem_rdy) begin e.irwr = 1'b1; e.pcwr = 1'b1; end
        e.mem_err = fire;
      end
      "D": begin
        if (c == C_ILL) e.illegal = 1'b1;
        if (c == C_J) begin e.pcwr = 1'b1; e.npc = 2'd2; end
      end
      "E": begin
        case (c)
          C_ADDU:  begin e.srcb = 2'd1; e.alu = 3'd0; end
          C_SUBU:  begin e.srcb = 2'd1; e.alu = 3'd1; end
          C_OR:    begin e.srcb = 2'd1; e.alu = 3'd2; end
          C_SLT:   begin e.srcb = 2'd1; e.alu = 3'd3; end
          C_SLL:   begin e.srca = 2'd2; e.srcb = 2'd1; e.alu = 3'd4; end
          C_SRL:   begin e.srca = 2'd2; e.srcb = 2'd1; e.alu = 3'd5; end
          C_ADDIU: begin e.ext = 2'd1; e.alu = 3'd0; end
          C_ORI:   begin e.ext = 2'd0; e.alu = 3'd2; end
          C_LUI:   begin e.ext = 2'd2; e.alu = 3'd2; end
          C_LW, C_SW: begin e.ext = 2'd1; e.alu = 3'd0; end
          C_BEQ, C_BNE: begin
            e.srcb = 2'd1; e.alu = 3'd1; e.ext = 2'd1;
            if ((c == C_BEQ) ? zero : !zero) begin e.pcwr = 1'b1; e.npc = 2'd1; end
          end
          C_JR:    begin e.pcwr = 1'b1; e.npc = 2'd3; end
          C_JAL:   begin e.srca = 2'd1; e.srcb = 2'd2; end
          default: ;
        endcase
      end
      "M": begin
        e.mem_req = 1'b1;
        e.mem_sel = 1'b1;
        e.dmwr    = (c == C_SW) && !fire;
        e.mem_err = fire;
      end
      "W": begin
        e.gprwr = 1'b1;
        if (c inside {C_ADDU, C_SUBU, C_OR, C_SLT, C_SLL, C_SRL, C_MFHI, C_MFLO}) e.regdst = 2'd1;
        if (c == C_LW)   e.m2r = 3'd1;
        if (c == C_MFHI) e.m2r = 3'd2;
        if (c == C_MFLO) e.m2r = 3'd3;
        if (c == C_JAL) begin e.regdst = 2'd2; e.pcwr = 1'b1; e.npc = 2'd2; end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Called exactly once per rising edge, before the bench changes any input.
  task automatic model_advance();
    byte   st;
    string s;
    if (!rst_n) begin in_init = 1'b1; idx = 0; w = 0; return; end
    if (in_init) begin in_init = 1'b0; idx = 0; w = 0; return; end
    st = stage_now();
    s  = seq_of(classify(op, funct));
    if (((st == "F") || (st == "M")) && !mem_rdy) begin
      if (fire_now()) begin idx = 0; w = 0; end
      else w++;
      return;
    end
    w = 0;
    idx++;
    if (idx >= s.len()) idx = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("cyc%0d stage %c outputs", cyc, stage_now()), dut_outs, expect_out());
      cyc++;
    end
  end

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
    @(posedge clk);
    model_advance();
    #1;
    op = o; funct = f; zero = z; mem_rdy = r;
    @(negedge clk);
    #1;
  endtask

  logic [5:0] r_fn [9] = '{6'h21, 6'h23, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h10, 6'h12};
  logic [5:0] i_op [9] = '{6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  task automatic pick_instr();
    int k;
    k = $urandom_range(0, 21);
    if (k < 9) begin
      op = 6'h00; funct = r_fn[k];
    end else if (k < 18) begin
      op = i_op[k-9]; funct = 6'($urandom);
    end else begin
      case (k)
        18:      begin op = 6'h3F; funct = 6'($urandom); end
        19:      begin op = 6'h00; funct = 6'h3F; end
        20:      begin op = 6'h10; funct = 6'($urandom); end
        default: begin op = 6'h20; funct = 6'($urandom); end
      endcase
    end
  endtask

  initial begin
    int rdy_pct;
    rst_n = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b0;
    in_init = 1'b1; idx = 0; w = 0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_req", mem_req, 0);
    check("reset all outputs", dut_outs, 0);
    rst_n = 1'b1;

    // addu $3,$1,$2
    drive(6'h00, 6'h21, 1'b0, 1'b1); check("addu c1 IRWr", IRWr, 1);
    drive(6'h00, 6'h21, 1'b0, 1'b1); check("addu c2 PCWr", PCWr, 0);
    drive(6'h00, 6'h21, 1'b0, 1'b1); check("addu c3 ALUSrcB", ALUSrcB, 1);
    drive(6'h00, 6'h21, 1'b0, 1'b1);
    check("addu c4 GPRWr", GPRWr, 1);
    check("addu c4 RegDst", RegDst, 1);
    check("addu c4 MemtoReg", MemtoReg, 0);

    // lw $3,4($2) with 3 wait cycles in MEM
    drive(6'h23, 6'h04, 1'b0, 1'b1); check("lw fetch IRWr", IRWr, 1);
    drive(6'h23, 6'h04, 1'b0, 1'b1);
    drive(6'h23, 6'h04, 1'b0, 1'b1);
    check("lw exe ExtOp", ExtOp, 1);
    check("lw exe ALUSrcB", ALUSrcB, 0);
    for (int i = 0; i < 4; i++) begin
      drive(6'h23, 6'h04, 1'b0, (i == 3));
      check($sformatf("lw mem_req %0d", i), {mem_req, mem_sel, DMWr}, 3'b110);
    end
    drive(6'h23, 6'h04, 1'b0, 1'b1);
    check("lw wb RegDst", RegDst, 0);
    check("lw wb MemtoReg", MemtoReg, 1);

    // beq taken, then not taken
    drive(6'h04, 6'h03, 1'b1, 1'b1);
    drive(6'h04, 6'h03, 1'b1, 1'b1);
    drive(6'h04, 6'h03, 1'b1, 1'b1);
    check("beq taken PCWr/NPCOp", {PCWr, NPCOp}, 3'b101);
    drive(6'h04, 6'h03, 1'b0, 1'b1); check("beq back in fetch", {mem_req, IRWr}, 2'b11);
    drive(6'h04, 6'h03, 1'b0, 1'b1);
    drive(6'h04, 6'h03, 1'b0, 1'b1); check("beq not taken PCWr", PCWr, 0);

    // jal
    drive(6'h03, 6'h10, 1'b0, 1'b1);
    drive(6'h03, 6'h10, 1'b0, 1'b1);
    drive(6'h03, 6'h10, 1'b0, 1'b1);
    check("jal exe srcs", {ALUSrcA, ALUSrcB}, 4'b0110);
    drive(6'h03, 6'h10, 1'b0, 1'b1);
    check("jal wb", {GPRWr, RegDst, PCWr, NPCOp}, 6'b1_10_1_10);

    // illegal opcode, then a stuck memory until timeout
    drive(6'h3F, 6'h00, 1'b0, 1'b1);
    drive(6'h3F, 6'h00, 1'b0, 1'b1);
    check("illegal pulse", illegal, 1);
    check("illegal no strobes", {PCWr, IRWr, GPRWr, DMWr}, 4'b0000);
    for (int i = 1; i <= 6; i++) begin
      drive(6'h00, 6'h21, 1'b0, 1'b0);
      if (i == 1) check("after illegal fetch", {mem_req, mem_sel}, 2'b10);
      check($sformatf("timeout wait %0d mem_err", i), mem_err, (i == 6));
    end
    drive(6'h00, 6'h21, 1'b0, 1'b0);
    check("refetch after timeout", {mem_req, mem_err}, 2'b10);

    // reset in the middle of a data access
    drive(6'h23, 6'h04, 1'b0, 1'b1);
    drive(6'h23, 6'h04, 1'b0, 1'b1);
    drive(6'h23, 6'h04, 1'b0, 1'b1);
    drive(6'h23, 6'h04, 1'b0, 1'b0);
    check("mem before reset", {mem_req, mem_sel}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async reset mem_req", mem_req, 0);
    check("async reset outputs", dut_outs, 0);
    @(posedge clk);
    model_advance();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(6'h00, 6'h21, 1'b0, 1'b0);
    check("fetch after reset", {mem_req, mem_sel}, 2'b10);

    // randomized traffic
    rdy_pct = 100;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 100;
          1:       rdy_pct = 70;
          default: rdy_pct = 15;
        endcase
      end
      @(posedge clk);
      model_advance();
      #1;
      if (!in_init && (stage_now() == "F")) pick_instr();
      zero    = 1'($urandom_range(0, 1));
      mem_rdy = ($urandom_range(0, 99) < rdy_pct);
    end
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
